sad_window_accumulator: RTL
===========================

Name: sad_window_accumulator

Overview:
- Downstream consumer of the 8-bit Sklansky adder stage in the SAD datapath.
- Accepts a stream of 8-bit registered adder results (per-pixel absolute differences) over a valid/ready handshake.
- Accumulates exactly N_SAMPLES accepted values into a saturating ACC_W-bit sum.
- Presents the window SAD on an output valid/ready handshake to the neuron comparison logic.

Parameters:
N_SAMPLES, 16, number of accepted input samples per window; legal range 2..256
ACC_W, 12, accumulator and result width; must be >= 8; default holds 16*255 = 4080 without saturation

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to open a new accumulation window
in_valid  input  1  in_data carries a sample
in_data  input  8  sample from upstream adder stage (unsigned)
in_ready  output  1  block accepts a sample this cycle
out_valid  output  1  out_sad holds a completed window result
out_sad  output  ACC_W  window sum, unsigned, saturated
out_ready  input  1  downstream consumes result
busy  output  1  high in ACCUM or HOLD
overflow  output  1  sticky; saturation occurred in the current or last window

Behaviour:
- Reset (rst=1 at a clock edge, synchronous, active-high, any state, including mid-window): state=IDLE.
  - Accumulator, sample counter, out_sad and overflow cleared to 0.
  - out_valid=0, in_ready=0, busy=0. Takes priority over all other inputs.
- Sample accept = in_valid & in_ready at a clock edge. Result consume = out_valid & out_ready at a clock edge.
- States and transitions:
  - IDLE: in_ready=0, out_valid=0, busy=0.
    - start=1 -> ACCUM. Clear accumulator, counter and overflow.
  - ACCUM: in_ready=1, out_valid=0, busy=1. start is ignored.
    - On accept: acc <= sat(acc + in_data) and count <= count+1.
    - On the accept with count == N_SAMPLES-1 -> HOLD. out_sad <= final saturated sum.
    - No accept: hold all state; no timeout.
  - HOLD: out_valid=1, in_ready=0, busy=1. out_sad and overflow stable until consume.
    - Consume with start=0 -> IDLE.
    - Consume with start=1 -> ACCUM directly. Clear accumulator, counter and overflow; no idle bubble.
    - start without consume: ignored.
- Latency:
  - First in_ready is 1 cycle after start is sampled in IDLE.
  - out_valid rises in the cycle after the final accept.
  - Minimum window time is N_SAMPLES+1 cycles from start to out_valid.
- Arithmetic:
  - in_data is zero-extended to ACC_W bits.
  - The add uses ACC_W+1 bits internally. If the result exceeds 2^ACC_W-1, acc <= 2^ACC_W-1 and overflow <= 1.
  - Once saturated, acc stays saturated for the rest of the window.
- Counter: width clog2(N_SAMPLES); counts accepts only, not valid cycles; never wraps inside a window.
- out_sad outside HOLD: retains the last result; 0 after reset. Only defined as a result when out_valid=1.
- Single-cycle pulses on in_valid or out_ready are legal.
- X on in_data while in_valid=0 must not affect state.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> out_valid=0, in_ready=0, busy=0, out_sad=0, overflow=0.
- Back-to-back stream, defaults: start, then in_data=1..16 with in_valid held high and out_ready=1.
  - Expected: in_ready high 16 cycles; out_valid=1 exactly 1 cycle after 16th accept; out_sad=136, overflow=0; return to IDLE.
- Bubbles: same 1..16 data with in_valid toggling 1,0,0,1,...
  - Expected: out_sad=136; counter ignores invalid cycles; in_ready stays 1 throughout ACCUM.
- Backpressure and chaining: complete a window of all 10s (sum 160) with out_ready=0 for 6 cycles and start pulsed mid-hold.
  - While held: out_valid and out_sad=160 stable; in_ready=0; start ignored.
  - Then assert out_ready and start in the same cycle: next cycle state=ACCUM, in_ready=1, out_valid=0.
- Saturation: ACC_W=10, 16 samples of 255.
  - Expected: out_sad=1023, overflow=1.
  - Next start clears overflow=0; a window of 16 zeros yields out_sad=0.
- Reset mid-window: accept 7 samples of 200, assert rst 1 cycle.
  - Expected: IDLE, out_valid=0, busy=0.
  - Then start plus 16 samples of 3 -> out_sad=48, with no residue from the aborted window.

Source files
------------

// File: rtl/sad_window_accumulator.sv
// sad_window_accumulator
//   Collects a window of N_SAMPLES per-pixel absolute differences from the
//   upstream adder stage, sums them with saturation into an ACC_W-bit result,
//   and offers that window SAD to the downstream comparison logic.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      open a new accumulation window (IDLE, or HOLD together with consume)
//   in_valid   in_data carries a sample
//   in_data    8-bit unsigned sample
//   in_ready   a sample is accepted this cycle when in_valid is also high
//   out_valid  out_sad holds a completed window result
//   out_sad    saturated window sum
//   out_ready  downstream consumes the result
//   busy       window in progress or result waiting
//   overflow   sticky saturation flag for the current or last window
module sad_window_accumulator #(
  parameter int N_SAMPLES = 16,
  parameter int ACC_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sad,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int              CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   sad_q, sad_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               open_win;
  logic               sat_hit;
  logic [ACC_W-1:0]   sum_sat;

  // Both operands fit in ACC_W bits, so the ACC_W+1-bit sum can only exceed
  // the range through its top bit. Returns {saturated, clamped_sum}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [7:0]       b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W - 7){1'b0}}, b};
    if (s[ACC_W]) begin
      return {1'b1, {ACC_W{1'b1}}};
    end
    return s;
  endfunction

  assign accept   = in_valid && (state_q == ACCUM);
  // A new window opens from IDLE, or straight out of HOLD when the result is
  // consumed in the same cycle start is seen.
  assign open_win = start && ((state_q == IDLE) ||
                              ((state_q == HOLD) && out_ready));
  assign {sat_hit, sum_sat} = sat_add(acc_q, in_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sad_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sad_q   <= sad_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (accept && (cnt_q == LAST)) state_d = HOLD;
      HOLD:    if (out_ready) state_d = start ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sad_d = sad_q;
    ovf_d = ovf_q;
    if (open_win) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      acc_d = sum_sat;
      if (sat_hit) ovf_d = 1'b1;
      if (cnt_q == LAST) begin
        sad_d = sum_sat;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    busy      = (state_q == ACCUM) || (state_q == HOLD);
    out_sad   = sad_q;
    overflow  = ovf_q;
  end

endmodule
